piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, shift-enable pacing and frame-boundary flags. It is the next generation of the team's 4-bit load/shift PISO register. It adds configurable width, back-to-back frame streaming without idle gaps, and status outputs so it can drive a serial link or bit-banged peripheral directly.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on OUT when no frame is active.

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN  input  WIDTH  parallel word to serialize, sampled on load.
- LOAD_VALID  input  1  source has a word on IN.
- LOAD_READY  output  1  serializer accepts IN this cycle (combinational).
- EN  input  1  shift enable / bit-rate strobe.
- OUT  output  1  serial data, registered.
- OUT_VALID  output  1  OUT carries a frame bit.
- LAST  output  1  OUT carries the final bit of the current frame.
- BUSY  output  1  frame in progress (equals OUT_VALID).

## Operation
- Two states: IDLE and SHIFT. Internal registers are a WIDTH-bit shift register and a bit counter of width clog2(WIDTH).
- Load: a word is accepted on a rising edge where LOAD_VALID && LOAD_READY. On acceptance, IN is captured, the counter clears to 0, the state becomes SHIFT, and OUT is driven with the first bit (IN[WIDTH-1] if MSB_FIRST, else IN[0]).
- LOAD_READY = (state==IDLE) || (state==SHIFT && count==WIDTH-1 && EN).
- SHIFT: on each edge with EN=1, the register shifts toward the output end, the counter increments, and OUT takes the next bit. With EN=0, all state holds and OUT is stable.
- End of frame: when count==WIDTH-1 and EN=1:
  - with a new word accepted that edge, go directly to the new frame (no gap);
  - otherwise go to IDLE and drive OUT=IDLE_LEVEL.
- LAST = (state==SHIFT && count==WIDTH-1).
- LOAD_VALID while LOAD_READY=0 is ignored. The source must hold IN and LOAD_VALID until it is accepted.
- EN in IDLE has no effect. A load does not require EN.
- Vacated bit positions fill with 0.

## Timing
- Reset values (asynchronous, immediate): state IDLE, shift register 0, counter 0, OUT=IDLE_LEVEL, OUT_VALID=0, LAST=0, BUSY=0. LOAD_READY=1 one delta after reset, while RST is held.
- RST asserted mid-frame aborts the frame with no further bits. The first load is accepted on the first rising edge after RST deasserts.
- Load-to-first-bit latency: 1 edge. The first bit appears on OUT immediately after the accepting edge.
- With EN tied high, each bit lasts 1 cycle, a frame lasts WIDTH cycles, and back-to-back frames give continuous OUT_VALID.
- With EN strobing every N cycles, each bit after the first is held until an EN edge. The first bit is held from load until the first EN edge.
- OUT, OUT_VALID, LAST and BUSY are registered outputs. LOAD_READY is combinational from state, count and EN.

## Test plan
- WIDTH=8, MSB_FIRST=1, EN=1, load IN=8'b1011_0010 -> OUT = 1,0,1,1,0,0,1,0 on 8 consecutive cycles; LAST high on the 8th cycle only; then OUT=0 and BUSY=0.
- WIDTH=4, MSB_FIRST=0, EN=1, load IN=4'b1011 -> OUT = 1,1,0,1; OUT_VALID high for exactly 4 cycles.
- WIDTH=4, EN=1, LOAD_VALID held high with 4'b1100 then 4'b0011 -> OUT = 1,1,0,0,0,0,1,1 with no idle cycle; LOAD_READY high exactly on the LAST cycle.
- WIDTH=8, EN pulsed 1 of every 3 cycles, load 8'hA5 -> each bit held 3 cycles; sequence 1,0,1,0,0,1,0,1; frame spans 24 cycles.
- WIDTH=8, load 8'hFF with EN=1, assert RST asynchronously after 3 bits -> OUT=0 and BUSY=0 immediately; after release, loading 8'h01 gives 0,0,0,0,0,0,0,1.
- WIDTH=8, load 8'hF0, then present LOAD_VALID with 8'h0F during bits 2..6 -> LOAD_READY stays 0 and 8'h0F is ignored until the LAST cycle, where it is accepted and streams next.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in/serial-out serializer with a valid/ready load handshake,
// selectable bit order, shift-enable pacing and frame-boundary flags.
// A new word can be accepted on the last bit of the current frame, so
// frames stream back to back without idle gaps.
//
// Parameters:
//   WIDTH      parallel word width in bits (2..64)
//   MSB_FIRST  1 = IN[WIDTH-1] leaves first, 0 = IN[0] leaves first
//   IDLE_LEVEL level driven on OUT when no frame is active
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   IN          parallel word, captured on an accepted load
//   LOAD_VALID  source offers a word on IN
//   LOAD_READY  word on IN is accepted this cycle (combinational)
//   EN          shift enable / bit-rate strobe
//   OUT         serial data (registered)
//   OUT_VALID   OUT carries a frame bit (registered)
//   LAST        OUT carries the final bit of the frame (registered)
//   BUSY        frame in progress, same as OUT_VALID
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             EN,
  output logic             OUT,
  output logic             OUT_VALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             at_end;
  logic             accept;
  logic             advance;
  logic             finish;
  logic [WIDTH-1:0] shifted;
  logic             next_bit;
  logic             first_bit;

  // The shift register always holds the bit currently on OUT at its
  // output end, so the next bit is the one just behind it.
  assign shifted   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign first_bit = MSB_FIRST ? IN[WIDTH-1] : IN[0];

  // A new word may enter while idle, or on the edge that retires the
  // final bit of the current frame; that second case gives gapless streaming.
  assign at_end     = (state_q == SHIFT) && (count_q == LAST_CNT);
  assign LOAD_READY = (state_q == IDLE) || (at_end && EN);
  assign accept     = LOAD_VALID && LOAD_READY;
  assign advance    = (state_q == SHIFT) && EN && !at_end;
  assign finish     = at_end && EN && !LOAD_VALID;

  // State register: FSM state, datapath and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: load takes priority, then shifting, then frame end.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = IN;
      count_d = '0;
    end else if (advance) begin
      shreg_d = shifted;
      count_d = count_q + CW'(1);
    end else if (finish) begin
      state_d = IDLE;
      shreg_d = '0;
      count_d = '0;
    end
  end

  // Output logic: computes the values the output flops take on the edge,
  // so OUT/OUT_VALID/LAST change together with the state they describe.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      out_d   = first_bit;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (advance) begin
      out_d   = next_bit;
      last_d  = (count_d == LAST_CNT);
    end else if (finish) begin
      out_d   = IDLE_LEVEL;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = valid_q;
  assign LAST      = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Self-checking bench for piso_serializer. Three instances cover
// WIDTH=8 MSB-first, WIDTH=4 LSB-first and WIDTH=4 MSB-first.
// Expected serial bits (with their LAST flag) are queued when a word is
// offered and popped by a negedge monitor whenever OUT_VALID is high.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst;

  logic [7:0] in8;
  logic       lv8, rdy8, en8, out8, val8, last8, busy8;
  logic [3:0] in4l;
  logic       lv4l, rdy4l, en4l, out4l, val4l, last4l, busy4l;
  logic [3:0] in4m;
  logic       lv4m, rdy4m, en4m, out4m, val4m, last4m, busy4m;

  exp_t q8[$];
  exp_t q4l[$];
  exp_t q4m[$];

  int tests_run;
  int tests_failed;
  int valid_cnt[3];
  int rise_cnt[3];
  logic prev_valid[3];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
    .CLK(clk), .RST(rst), .IN(in8), .LOAD_VALID(lv8), .LOAD_READY(rdy8),
    .EN(en8), .OUT(out8), .OUT_VALID(val8), .LAST(last8), .BUSY(busy8)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4l (
    .CLK(clk), .RST(rst), .IN(in4l), .LOAD_VALID(lv4l), .LOAD_READY(rdy4l),
    .EN(en4l), .OUT(out4l), .OUT_VALID(val4l), .LAST(last4l), .BUSY(busy4l)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut4m (
    .CLK(clk), .RST(rst), .IN(in4m), .LOAD_VALID(lv4m), .LOAD_READY(rdy4m),
    .EN(en4m), .OUT(out4m), .OUT_VALID(val4m), .LAST(last4m), .BUSY(busy4m)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  // Queue the expected serial bits of a word, each repeated for the
  // number of cycles it is expected to stay on OUT.
  task automatic push_word(input int which, input logic [7:0] word, input int width,
                           input bit msb, input int hold);
    exp_t e;
    logic [7:0] w;
    w = word;
    for (int i = 0; i < width; i++) begin
      e.b    = msb ? w[width-1-i] : w[i];
      e.last = (i == width - 1);
      for (int h = 0; h < hold; h++) begin
        case (which)
          0:       q8.push_back(e);
          1:       q4l.push_back(e);
          default: q4m.push_back(e);
        endcase
      end
    end
  endtask

  // Offer a word to one instance and hold it until the handshake completes.
  // Returns one time unit after the accepting edge with LOAD_VALID dropped.
  task automatic applyStimulus(input int which, input logic [7:0] word, input int hold);
    logic acc;
    int   budget;
    acc = 1'b0;
    budget = 0;
    case (which)
      0: begin in8 = word; lv8 = 1'b1; push_word(0, word, 8, 1'b1, hold); end
      1: begin in4l = word[3:0]; lv4l = 1'b1; push_word(1, word, 4, 1'b0, hold); end
      default: begin in4m = word[3:0]; lv4m = 1'b1; push_word(2, word, 4, 1'b1, hold); end
    endcase
    while (!acc && budget < 50) begin
      @(negedge clk);
      case (which)
        0:       acc = rdy8;
        1:       acc = rdy4l;
        default: acc = rdy4m;
      endcase
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput($sformatf("d%0d_load_accepted", which), {63'd0, acc}, 64'd1);
    case (which)
      0:       lv8 = 1'b0;
      1:       lv4l = 1'b0;
      default: lv4m = 1'b0;
    endcase
  endtask

  // Per-instance scoreboard check on the falling edge.
  task automatic monitor_dut(input int which, input logic valid, input logic out,
                             input logic last, input logic busy, input logic ready,
                             input logic en);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (valid) begin
      case (which)
        0:       if (q8.size() > 0)  begin e = q8.pop_front();  have = 1'b1; end
        1:       if (q4l.size() > 0) begin e = q4l.pop_front(); have = 1'b1; end
        default: if (q4m.size() > 0) begin e = q4m.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        checkOutput($sformatf("d%0d_unexpected_valid", which), {63'd0, valid}, 64'd0);
      end else begin
        checkOutput($sformatf("d%0d_bit", which), {63'd0, out}, {63'd0, e.b});
        checkOutput($sformatf("d%0d_last", which), {63'd0, last}, {63'd0, e.last});
        checkOutput($sformatf("d%0d_ready_busy", which), {63'd0, ready}, {63'd0, e.last && en});
      end
      checkOutput($sformatf("d%0d_busy", which), {63'd0, busy}, 64'd1);
      valid_cnt[which]++;
      if (!prev_valid[which]) rise_cnt[which]++;
    end else begin
      checkOutput($sformatf("d%0d_idle_out", which), {63'd0, out}, 64'd0);
      checkOutput($sformatf("d%0d_idle_last", which), {63'd0, last}, 64'd0);
      checkOutput($sformatf("d%0d_idle_busy", which), {63'd0, busy}, 64'd0);
      checkOutput($sformatf("d%0d_idle_ready", which), {63'd0, ready}, 64'd1);
    end
    prev_valid[which] = valid;
  endtask

  // Monitor all three instances whenever reset is released.
  always @(negedge clk) begin
    if (!rst) begin
      monitor_dut(0, val8, out8, last8, busy8, rdy8, en8);
      monitor_dut(1, val4l, out4l, last4l, busy4l, rdy4l, en4l);
      monitor_dut(2, val4m, out4m, last4m, busy4m, rdy4m, en4m);
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 3; i++) begin
      valid_cnt[i]  = 0;
      rise_cnt[i]   = 0;
      prev_valid[i] = 1'b0;
    end
    in8 = '0;  lv8 = 1'b0;  en8 = 1'b0;
    in4l = '0; lv4l = 1'b0; en4l = 1'b0;
    in4m = '0; lv4m = 1'b0; en4m = 1'b0;
    rst = 1'b1;

    // Reset state while reset is held
    #1;
    checkOutput("rst_out", {63'd0, out8}, 64'd0);
    checkOutput("rst_valid", {63'd0, val8}, 64'd0);
    checkOutput("rst_last", {63'd0, last8}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy8}, 64'd0);
    checkOutput("rst_ready", {63'd0, rdy8}, 64'd1);
    checkOutput("rst_ready_4l", {63'd0, rdy4l}, 64'd1);
    checkOutput("rst_ready_4m", {63'd0, rdy4m}, 64'd1);
    #11;
    rst = 1'b0;

    // WIDTH=8 MSB-first, EN tied high
    @(posedge clk); #1;
    en8 = 1'b1;
    applyStimulus(0, 8'b1011_0010, 1);
    repeat (10) @(posedge clk);
    #1;

    // WIDTH=4 LSB-first, exactly four valid cycles
    en4l = 1'b1;
    valid_cnt[1] = 0;
    applyStimulus(1, 8'h0B, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("lsb_valid_cycles", valid_cnt[1], 64'd4);

    // WIDTH=4 back-to-back frames with LOAD_VALID held
    en4m = 1'b1;
    valid_cnt[2] = 0;
    rise_cnt[2]  = 0;
    applyStimulus(2, 8'h0C, 1);
    applyStimulus(2, 8'h03, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("b2b_valid_cycles", valid_cnt[2], 64'd8);
    checkOutput("b2b_frame_starts", rise_cnt[2], 64'd1);

    // WIDTH=8 with EN pulsed once every three cycles
    en8 = 1'b0;
    valid_cnt[0] = 0;
    applyStimulus(0, 8'hA5, 3);
    for (int k = 0; k < 8; k++) begin
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      en8 = 1'b1;
      @(posedge clk);
      #1;
      en8 = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("paced_frame_cycles", valid_cnt[0], 64'd24);

    // Word offered mid-frame waits for the LAST cycle, then streams next
    en8 = 1'b1;
    applyStimulus(0, 8'hF0, 1);
    @(posedge clk);
    #1;
    applyStimulus(0, 8'h0F, 1);
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset mid-frame, then a fresh load
    applyStimulus(0, 8'hFF, 1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_out", {63'd0, out8}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy8}, 64'd0);
    checkOutput("abort_last", {63'd0, last8}, 64'd0);
    checkOutput("abort_ready", {63'd0, rdy8}, 64'd1);
    q8.delete();
    prev_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(0, 8'h01, 1);
    repeat (10) @(posedge clk);
    #1;

    // Every queued bit must have been seen
    checkOutput("q8_drained", q8.size(), 64'd0);
    checkOutput("q4l_drained", q4l.size(), 64'd0);
    checkOutput("q4m_drained", q4m.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
